// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared definitions for the data-memory responder and its helpers.
//   state_t   : responder FSM encoding (IDLE, WAIT, RESP)
//   DATA_W    : data path width in bits
//   STRB_W    : number of byte enables per word
//   LFSR_SEED : reset value of the optional random-latency LFSR
package mem_if_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16 + x^14 + x^13 + x^11 + 1).
// It is seeded to LFSR_SEED on reset and advances every clock cycle.
// The top module uses it only when MEM_RAND_LAT_EN is defined.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   state  : current 16-bit LFSR state
module lfsr16
  import mem_if_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] state
);

  logic feedback;

  // Tap positions 16,14,13,11 are 1-based; in 0-based bits they are 15,13,12,10.
  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= LFSR_SEED;
    end else begin
      state <= {state[14:0], feedback};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the CPU data-memory request interface.
// It accepts one read or write at a time, waits a configurable number of
// cycles, commits byte-masked writes, and returns read data through a
// valid/ready handshake. Storage is a word-addressed array of 2**DEPTH_LOG2
// words.
//
// Optional build macro MEM_RAND_LAT_EN: when it is defined, a free-running
// LFSR adds 0..7 extra wait cycles to each request.
//
// Parameters:
//   DEPTH_LOG2 : log2 of storage depth in 32-bit words (4..16)
//   LATENCY    : base wait cycles between accept and access (0..15)
// Ports:
//   clk             : rising-edge clock
//   resetn          : asynchronous active-low reset
//   Address         : byte address; [1:0] and bits above DEPTH_LOG2+1 ignored
//   MemWrite        : write request
//   MemRead         : read request (a write wins if both are high)
//   Write_data      : write data
//   Write_strb      : byte enables; bit i enables byte i
//   Mem_Req_Ready   : responder can accept a request this cycle
//   Read_data       : read response data
//   Read_data_Valid : Read_data is valid
//   Read_data_Ready : initiator accepts the read response
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [STRB_W-1:0] Write_strb,
  output logic              Mem_Req_Ready,
  output logic [DATA_W-1:0] Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef MEM_RAND_LAT_EN
  localparam int CNT_W = 5;  // LATENCY (max 15) + 7 extra cycles fits in 5 bits
`else
  localparam int CNT_W = 4;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [DATA_W-1:0]       wdata;
  logic [STRB_W-1:0]       wstrb;
  logic                    is_write;

  logic [DATA_W-1:0]       mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    accept;
  logic                    done;
  logic                    mem_we;
  logic [CNT_W-1:0]        lat_load;

  // Address bits outside the word index only alias, so they are dropped.
  logic                    addr_unused;

  assign req_idx     = Address[DEPTH_LOG2+1:2];
  assign addr_unused = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

  assign accept = (state == IDLE) && (MemRead || MemWrite);
  assign done   = (state == WAIT) && (cnt == '0);
  assign mem_we = done && is_write;

`ifdef MEM_RAND_LAT_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .state  (lfsr)
  );

  assign lat_load    = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
  assign lfsr_unused = ^lfsr[15:3];
`else
  assign lat_load = CNT_W'(LATENCY);
`endif

  // NOTE: the storage array has no reset. A reset here would turn the RAM into
  // a large bank of flops, and the contents have no defined reset value.
  // Writes are ignored during reset because the FSM is then held in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs. A read samples the array
  // one or more cycles after any earlier write committed, so it always sees
  // the data that write left behind.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from pre-edge values, and there is no ordering race between
  // always_ff blocks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      wdata           <= '0;
      wstrb           <= '0;
      is_write        <= 1'b0;
      Mem_Req_Ready   <= 1'b1;
      Read_data_Valid <= 1'b0;
      Read_data       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            idx           <= req_idx;
            wdata         <= Write_data;
            wstrb         <= Write_strb;
            is_write      <= MemWrite;  // write wins when both are high
            cnt           <= lat_load;
            Mem_Req_Ready <= 1'b0;
            state         <= WAIT;
          end
        end

        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (is_write) begin
            Mem_Req_Ready <= 1'b1;
            state         <= IDLE;
          end else begin
            Read_data       <= mem[idx];
            Read_data_Valid <= 1'b1;
            state           <= RESP;
          end
        end

        RESP: begin
          // Read_data deliberately keeps its value after the handshake.
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            Mem_Req_Ready   <= 1'b1;
            state           <= IDLE;
          end
        end

        default: begin
          state           <= IDLE;
          Mem_Req_Ready   <= 1'b1;
          Read_data_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder, built with the default configuration
// (MEM_RAND_LAT_EN undefined, DEPTH_LOG2=10, LATENCY=2). Each read request
// pushes its expected data into a queue. A monitor pops that entry on the
// first cycle of each response and compares. The stimulus side checks
// handshake timing and hold behaviour.
module tb_mem_responder;

  localparam int DL2 = 10;
  localparam int LAT = 2;
  localparam int MAX_WAIT = 50;

  logic        clk;
  logic        resetn;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q [$];
  bit          resp_seen = 1'b0;

  mem_responder #(
    .DEPTH_LOG2 (DL2),
    .LATENCY    (LAT)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the data of each response on its first valid cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      resp_seen = 1'b0;
    end else if (Read_data_Valid && !resp_seen) begin
      resp_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'd0, Read_data_Valid}, 32'd0);
      end else begin
        check("rd_data", Read_data, exp_q.pop_front());
      end
    end else if (!Read_data_Valid) begin
      resp_seen = 1'b0;
    end
  end

  // Waits for Mem_Req_Ready, then presents one request for exactly one edge.
  // After that edge (the accept edge) the inputs hold junk, because the
  // responder must have captured them already.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sb);
    int n = 0;
    while (!Mem_Req_Ready && n < MAX_WAIT) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_before_issue", {31'd0, Mem_Req_Ready}, 32'd1);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = data;
    Write_strb = sb;
    @(posedge clk); #1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 32'hFFFF_FFFC;
    Write_data = 32'h0BAD_0BAD;
    Write_strb = 4'hF;
  endtask

  // Counts cycles from the accept edge until Mem_Req_Ready returns.
  task automatic wait_write_done(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!Mem_Req_Ready && n < MAX_WAIT);
    check(name, 32'(n), 32'(LAT + 1));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sb);
    issue(1'b0, 1'b1, addr, data, sb);
    wait_write_done("wr_turnaround");
  endtask

  // hold == 0: Ready is raised early, before Valid. This must not count as a
  // handshake. hold > 0: Ready stays low for hold cycles after Valid rises.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input int hold);
    int n = 0;
    exp_q.push_back(exp);
    Read_data_Ready = (hold == 0);
    issue(1'b1, 1'b0, addr, 32'h0, 4'h0);
    do begin
      @(posedge clk); #1; n++;
    end while (!Read_data_Valid && n < MAX_WAIT);
    check("rd_latency", 32'(n), 32'(LAT + 1));
    check("rd_busy_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, Read_data_Valid}, 32'd1);
      check("hold_data", Read_data, exp);
      check("hold_req_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    end
    Read_data_Ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", {31'd0, Read_data_Valid}, 32'd0);
    check("post_hs_idle", {31'd0, Mem_Req_Ready}, 32'd1);
    check("post_hs_data_kept", Read_data, exp);
    Read_data_Ready = 1'b0;
  endtask

  initial begin
    resetn          = 1'b0;
    Address         = 32'h0;
    MemWrite        = 1'b0;
    MemRead         = 1'b0;
    Write_data      = 32'h0;
    Write_strb      = 4'h0;
    Read_data_Ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, Mem_Req_Ready}, 32'd1);
    check("rst_valid", {31'd0, Read_data_Valid}, 32'd0);
    check("rst_rdata", Read_data, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic full-word write and readback.
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h10, 32'hDEAD_BEEF, 0);

    // Byte-masked merge: bytes 0 and 2 come from the new data.
    do_write(32'h20, 32'h1122_3344, 4'hF);
    do_write(32'h20, 32'hAABB_CCDD, 4'b0101);
    do_read(32'h20, 32'h11BB_33DD, 0);

    // A zero strobe still runs the full latency but leaves storage unchanged.
    do_write(32'h20, 32'h0000_0000, 4'b0000);
    do_read(32'h20, 32'h11BB_33DD, 0);

    // Response held for 5 cycles by a stalled initiator.
    do_read(32'h10, 32'hDEAD_BEEF, 5);

    // Address aliasing above bit DL2+1.
    do_write(32'h0000_1004, 32'h0000_0005, 4'hF);
    do_read(32'h0000_0004, 32'h0000_0005, 0);

    // Read and write together: treated as a write, so no response appears.
    issue(1'b1, 1'b1, 32'h30, 32'h0000_0007, 4'hF);
    wait_write_done("rw_both_turnaround");
    do_read(32'h30, 32'h0000_0007, 0);

    // Reset during the WAIT of a write drops the write.
    do_write(32'h40, 32'h1234_5678, 4'hF);
    do_read(32'h40, 32'h1234_5678, 0);
    issue(1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("midrst_req_ready", {31'd0, Mem_Req_Ready}, 32'd1);
    check("midrst_valid", {31'd0, Read_data_Valid}, 32'd0);
    check("midrst_rdata", Read_data, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    do_read(32'h40, 32'h1234_5678, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the CPU control path (MemRead/MemWrite initiator).
- Accepts one read or write request at a time with a ready handshake, applies a configurable access latency, commits byte-masked writes, and returns read data with a valid/ready handshake.
- Holds a word-addressed internal storage array.
- Serves as the data-memory model for the multi-cycle core and as a reusable slave for core testbenches.

Parameters:
- DEPTH_LOG2, 10, log2 of storage depth in 32-bit words; legal range 4..16.
- LATENCY, 2, base wait cycles between request accept and access completion; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- Address  input  32  byte address; bits [1:0] ignored; bits above DEPTH_LOG2+1 ignored.
- MemWrite  input  1  write request.
- MemRead  input  1  read request.
- Write_data  input  32  write data.
- Write_strb  input  4  byte enables; bit i enables byte i (bits 8i+7:8i).
- Mem_Req_Ready  output  1  responder can accept a request this cycle.
- Read_data  output  32  read response data.
- Read_data_Valid  output  1  Read_data is valid.
- Read_data_Ready  input  1  initiator accepts the read response.

Behaviour:
- Clocking and reset: one clock (clk); resetn is asynchronous, active-low.
- Reset values: state IDLE, Mem_Req_Ready=1, Read_data_Valid=0, Read_data=32'h0, latency counter 0. Storage contents are not reset.
- States: IDLE, WAIT, RESP. Mem_Req_Ready=1 only in IDLE; Read_data_Valid=1 only in RESP.
- Accept: at a rising edge where state is IDLE and (MemRead|MemWrite)=1.
  - Captures Address word index, Write_data, Write_strb and request type.
  - Loads the counter with LATENCY; transitions to WAIT.
  - Inputs are don't-care after the accept edge.
- Both MemRead and MemWrite high at accept: treated as a write only. No read response is produced.
- WAIT with counter!=0: counter decrements by 1 per cycle.
- WAIT with counter==0, at the next edge:
  - Write: mem[idx] bytes with strb=1 updated, others unchanged; state -> IDLE.
  - Read: Read_data <= mem[idx] (post any earlier write); Read_data_Valid <= 1; state -> RESP.
- Timing from the accept edge E:
  - Read: Read_data_Valid first high LATENCY+1 cycles after E.
  - Write: Mem_Req_Ready high again LATENCY+1 cycles after E.
  - LATENCY=0 therefore gives a 1-cycle turnaround.
- RESP: Read_data and Valid are held stable until an edge with Read_data_Ready=1. At that edge, Valid <= 0 and state -> IDLE.
  - Read_data keeps its last value after the handshake.
  - Ready may be high before Valid; this is not a handshake.
- Back-to-back: a new request is accepted the first cycle Mem_Req_Ready=1. There is no request/response overlap.
- Address wrap: idx = Address[DEPTH_LOG2+1:2]; higher bits alias.
- Write_strb=4'b0000 write: full handshake and latency, storage unchanged.
- Reset mid-operation: returns immediately to the reset values. A pending write is dropped. An outstanding read response is lost.

Optional Feature:
- Macro: MEM_RAND_LAT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - At accept, the counter loads LATENCY + lfsr[2:0], so per-request latency is LATENCY..LATENCY+7 wait cycles. Counter width grows to 5 bits.
  - All handshake rules are unchanged.
- Undefined: no LFSR logic; latency is fixed at LATENCY.

Decomposition:
- Shared package mem_if_pkg holds:
  - state encoding typedef (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - DATA_W=32;
  - STRB_W=4;
  - LFSR seed constant 16'hACE1.
- One natural sub-module: lfsr16 (clk, resetn, 16-bit state out), instantiated only under MEM_RAND_LAT_EN.

Test Plan:
- Reset, then write Address=32'h10, Write_data=32'hDEADBEEF, strb=4'hF; read 32'h10 with LATENCY=2.
  - Read_data=32'hDEADBEEF; Valid rises exactly 3 cycles after the read accept edge.
- Write 32'h11223344 to 32'h20, then write 32'hAABBCCDD with strb=4'b0101, then read.
  - Result 32'h11BB33DD.
- Read with Read_data_Ready held low 5 cycles after Valid.
  - Valid and data stable 5 cycles; Mem_Req_Ready=0 throughout; IDLE one cycle after the Ready edge.
- DEPTH_LOG2=10: write 32'h5 to address 32'h0000_1004, read address 32'h0000_0004.
  - Returns 32'h5 (alias).
- MemRead=MemWrite=1 with Write_data=32'h7.
  - No Valid pulse; a subsequent read returns 32'h7.
- Assert resetn=0 during WAIT of a write.
  - Outputs are at reset values the same cycle; the target word is unchanged on a later read.
